// File: rtl/waiz_layer_sequencer.sv
// Control FSM for the dense MLP core: walks layers/neurons/inputs and emits ROM/RAM addresses plus MAC, bias, ReLU and write strobes.
// Optional build macro WAIZ_SEQ_PERF_EN adds the perf_cycles latency counter output.
module waiz_layer_sequencer #(
  parameter int WIDTH    = 16,
  parameter int NFRAC    = 10,
  parameter int N_LAYERS = 4,
  parameter int DIMS [N_LAYERS+1] = '{16, 64, 32, 32, 5},
  parameter int RD_LAT   = 1,
  parameter int W_AW     = 13,
  parameter int B_AW     = 8,
  parameter int A_AW     = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            input_ready,
  output logic            in_capture,
  output logic            busy,
  output logic            output_ready,
  output logic [1:0]      layer_idx,
  output logic [W_AW-1:0] w_addr,
  output logic [B_AW-1:0] b_addr,
  output logic [A_AW-1:0] act_rd_addr,
  output logic            act_rd_bank,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            bias_en,
  output logic            relu_en,
  output logic            act_wr_en,
  output logic [A_AW-1:0] act_wr_addr
`ifdef WAIZ_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  // Handshake: input_ready is a start request accepted only in IDLE (in_capture
  // marks the accepting cycle); output_ready is a level held until the next accept.
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_DRAIN, S_WB, S_DONE} state_t;

  localparam int       LI_W   = $clog2(N_LAYERS + 1);
  localparam logic [1:0] LAST_L = 2'(N_LAYERS - 1);
  // An out-of-range configuration never starts an inference.
  localparam bit       CFG_OK = (RD_LAT >= 1) && (RD_LAT <= 3) && (NFRAC < WIDTH);

  state_t            state_q, state_d;
  logic [A_AW-1:0]   i_q, i_d;
  logic [A_AW-1:0]   n_q, n_d;
  logic [1:0]        layer_q, layer_d;
  logic [1:0]        drain_q, drain_d;
  logic [W_AW-1:0]   w_ptr_q, w_ptr_d;
  logic [B_AW-1:0]   b_ptr_q, b_ptr_d;
  logic              fin_q, fin_d;
  logic              output_ready_q, output_ready_d;
  logic [RD_LAT-1:0] mac_pipe_q, mac_pipe_d;
  logic              mac_issue;
  logic [LI_W-1:0]   lidx_in, lidx_out;
  logic [A_AW-1:0]   last_i, last_n;

  assign lidx_in  = LI_W'(layer_q);
  assign lidx_out = lidx_in + LI_W'(1);
  assign last_i   = A_AW'(DIMS[lidx_in] - 1);
  assign last_n   = A_AW'(DIMS[lidx_out] - 1);

  always_comb begin
    state_d        = state_q;
    i_d            = i_q;
    n_d            = n_q;
    layer_d        = layer_q;
    drain_d        = drain_q;
    w_ptr_d        = w_ptr_q;
    b_ptr_d        = b_ptr_q;
    fin_d          = 1'b0;
    output_ready_d = output_ready_q;
    in_capture     = 1'b0;
    mac_issue      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (input_ready && CFG_OK) begin
          in_capture     = 1'b1;
          output_ready_d = 1'b0;
          state_d        = S_CLR;
          i_d            = '0;
          n_d            = '0;
          layer_d        = '0;
          drain_d        = '0;
          w_ptr_d        = '0;
          b_ptr_d        = '0;
        end
      end
      S_CLR: state_d = S_MAC;
      S_MAC: begin
        // Weights are laid out layer by layer, neuron-major, so the ROM
        // address is simply a running count of issued products.
        mac_issue = 1'b1;
        w_ptr_d   = w_ptr_q + W_AW'(1);
        if (i_q == last_i) begin
          i_d     = '0;
          state_d = S_DRAIN;
        end else begin
          i_d = i_q + A_AW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'(RD_LAT - 1)) begin
          drain_d = '0;
          state_d = S_WB;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_WB: begin
        b_ptr_d = b_ptr_q + B_AW'(1);
        state_d = S_CLR;
        if (n_q == last_n) begin
          n_d = '0;
          if (layer_q == LAST_L) state_d = S_DONE;
          else                   layer_d = layer_q + 2'd1;
        end else begin
          n_d = n_q + A_AW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        fin_d   = 1'b1;
        layer_d = '0;
        w_ptr_d = '0;
        b_ptr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // A start accepted in the same cycle wins over the pending completion.
    if (fin_q && !in_capture) output_ready_d = 1'b1;
  end

  always_comb begin
    mac_pipe_d    = mac_pipe_q;
    mac_pipe_d[0] = mac_issue;
    for (int k = 1; k < RD_LAT; k++) mac_pipe_d[k] = mac_pipe_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      i_q            <= '0;
      n_q            <= '0;
      layer_q        <= '0;
      drain_q        <= '0;
      w_ptr_q        <= '0;
      b_ptr_q        <= '0;
      fin_q          <= 1'b0;
      output_ready_q <= 1'b0;
      mac_pipe_q     <= '0;
    end else begin
      state_q        <= state_d;
      i_q            <= i_d;
      n_q            <= n_d;
      layer_q        <= layer_d;
      drain_q        <= drain_d;
      w_ptr_q        <= w_ptr_d;
      b_ptr_q        <= b_ptr_d;
      fin_q          <= fin_d;
      output_ready_q <= output_ready_d;
      mac_pipe_q     <= mac_pipe_d;
    end
  end

  assign busy         = (state_q == S_CLR) || (state_q == S_MAC) ||
                        (state_q == S_DRAIN) || (state_q == S_WB);
  assign output_ready = output_ready_q;
  assign layer_idx    = layer_q;
  assign w_addr       = w_ptr_q;
  assign b_addr       = b_ptr_q;
  assign act_rd_addr  = i_q;
  assign act_rd_bank  = layer_q[0];
  assign mac_clr      = (state_q == S_CLR);
  assign mac_en       = mac_pipe_q[RD_LAT-1];
  assign bias_en      = (state_q == S_WB);
  assign act_wr_en    = (state_q == S_WB);
  assign relu_en      = (state_q == S_WB) && (layer_q != LAST_L);
  assign act_wr_addr  = n_q;

`ifdef WAIZ_SEQ_PERF_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] perf_q, perf_d;

  // cnt_q equals the number of edges since the accepting edge, plus one.
  always_comb begin
    cnt_d  = in_capture ? 32'd1 : cnt_q + 32'd1;
    perf_d = perf_q;
    if (fin_q && !in_capture) perf_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_waiz_layer_sequencer.sv
// Bench for waiz_layer_sequencer: directed runs, write-level scoreboard, latency/abort checks.
module tb_waiz_layer_sequencer;

  localparam int RD_LAT = 1;
  localparam int SW     = 41;
  localparam int LIMIT  = 10000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        input_ready = 1'b0;
  logic        in_capture, busy, output_ready;
  logic [1:0]  layer_idx;
  logic [12:0] w_addr;
  logic [7:0]  b_addr;
  logic [5:0]  act_rd_addr;
  logic        act_rd_bank, mac_clr, mac_en, bias_en, relu_en, act_wr_en;
  logic [5:0]  act_wr_addr;
`ifdef WAIZ_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  waiz_layer_sequencer #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .input_ready(input_ready), .in_capture(in_capture),
    .busy(busy), .output_ready(output_ready), .layer_idx(layer_idx), .w_addr(w_addr),
    .b_addr(b_addr), .act_rd_addr(act_rd_addr), .act_rd_bank(act_rd_bank),
    .mac_clr(mac_clr), .mac_en(mac_en), .bias_en(bias_en), .relu_en(relu_en),
    .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr)
`ifdef WAIZ_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int dims  [5] = '{16, 64, 32, 32, 5};
  int wbase [4] = '{0, 1024, 3072, 4096};
  int bbase [4] = '{0, 64, 96, 128};

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] pack(input int layer, input int bank, input int relu,
      input int bias, input int wa, input int ba, input int mc, input int cc, input int fw);
    return {2'(layer), 1'(bank), 1'(relu), 1'(bias), 6'(wa), 8'(ba), 7'(mc), 2'(cc), 13'(fw)};
  endfunction

  function automatic int exp_latency();
    int t = 0;
    for (int l = 0; l < 4; l++) t += dims[l+1] * (dims[l] + RD_LAT + 2);
    return t + 2;
  endfunction

  // Monitor: rebuilds one record per neuron write and pops the scoreboard.
  int   mac_cnt = 0, clr_cnt = 0, first_w = 0;
  logic prev_clr = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mac_cnt = 0; clr_cnt = 0; first_w = 0; prev_clr = 1'b0;
    end else begin
      if (prev_clr) first_w = int'(w_addr);
      if (mac_en)   mac_cnt++;
      if (mac_clr)  clr_cnt++;
      if (act_wr_en) begin
        logic [SW-1:0] act_w, exp_w;
        act_w = pack(layer_idx, act_rd_bank, relu_en, bias_en, act_wr_addr, b_addr,
                     mac_cnt, clr_cnt, first_w);
        wr_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got 0x%0h expected none (t=%0t)", act_w, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check("neuron_write", 64'(act_w), 64'(exp_w));
        end
        mac_cnt = 0;
        clr_cnt = 0;
      end
      prev_clr = mac_clr;
    end
  end

  task automatic push_run();
    for (int l = 0; l < 4; l++)
      for (int n = 0; n < dims[l+1]; n++)
        exp_q.push_back(pack(l, l % 2, (l != 3) ? 1 : 0, 1, n, bbase[l] + n,
                             dims[l], 1, wbase[l] + n * dims[l]));
  endtask

  // Starts a run, optionally holding input_ready for `hold` cycles or poking it
  // again at edge `poke_at`; returns the accept-to-output_ready edge count.
  task automatic run(input int hold, input int poke_at, input logic or_before, output int lat);
    wr_count = 0;
    push_run();
    @(posedge clk); #1;
    check("output_ready_before_start", output_ready, or_before);
    input_ready = 1'b1;
    @(negedge clk);
    check("in_capture_on_accept", in_capture, 1'b1);
    @(posedge clk); #1;
    check("output_ready_clear_on_accept", output_ready, 1'b0);
    check("busy_after_accept", busy, 1'b1);
    lat = -1;
    for (int k = 1; k <= LIMIT; k++) begin
      input_ready = (k < hold) || (k == poke_at);
      if (input_ready) begin
        @(negedge clk);
        check("in_capture_ignored", in_capture, 1'b0);
      end
      @(posedge clk); #1;
      if (output_ready) begin
        lat = k;
        break;
      end
    end
    input_ready = 1'b0;
    check("latency", 64'(lat), 64'(exp_latency()));
    repeat (5) @(posedge clk);
    #1;
    check("output_ready_level", output_ready, 1'b1);
    check("busy_after_done", busy, 1'b0);
    check("writes_per_run", 64'(wr_count), 64'd133);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef WAIZ_SEQ_PERF_EN
    check("perf_cycles", perf_cycles, 64'(exp_latency()));
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   busy, 1'b0);
    check({tag, "_oready"}, output_ready, 1'b0);
    check({tag, "_strobes"}, {mac_clr, mac_en, bias_en, relu_en, act_wr_en, in_capture}, 6'b0);
    check({tag, "_layer"},  layer_idx, 2'd0);
    check({tag, "_addrs"},  {w_addr, b_addr, act_rd_addr, act_wr_addr, act_rd_bank}, 34'd0);
`ifdef WAIZ_SEQ_PERF_EN
    check({tag, "_perf"},   perf_cycles, 32'd0);
`endif
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_outputs("reset");

    // Nominal run: full write sequence, addresses, relu, latency.
    run(1, -1, 1'b0, lat);
    // Start after completion, with a stray pulse mid-run.
    run(1, 100, 1'b1, lat);
    // input_ready held high across the accept: exactly one run.
    run(3, -1, 1'b1, lat);

    // Abort during layer 1, then a clean restart.
    wr_count = 0;
    push_run();
    @(posedge clk); #1;
    input_ready = 1'b1;
    @(posedge clk); #1;
    input_ready = 1'b0;
    repeat (1500) @(posedge clk);
    #1;
    check("layer_before_abort", layer_idx, 2'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    reset = 1'b0;
    exp_q.delete();
    wr_count = 0;
    repeat (50) @(posedge clk);
    #1;
    check("writes_after_abort", 64'(wr_count), 64'd0);
    run(1, -1, 1'b0, lat);

    check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
